// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and default frame parameters for serial_frame_rx.
package serial_pkg;

  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_SYNC_W   = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Counter width that stays legal for a 1-bit payload.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_detect.sv
// rtl/sync_detect.sv - sliding-window sync search with fill count; match_o flags the completing sample.
module sync_detect
  import serial_pkg::*;
#(
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic sample_i,
  input  logic din_i,
  output logic match_o
);

  localparam int FILL_W = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] hist_q, hist_d;
  logic [SYNC_W-1:0] shifted;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign shifted = {hist_q[SYNC_W-2:0], din_i};

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (sample_i) begin
      hist_d = shifted;
      if (fill_q != FILL_W'(SYNC_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // The fill gate keeps the zeroed history from matching patterns that contain zeros.
  assign match_o = sample_i && !clear_i &&
                   (fill_q >= FILL_W'(SYNC_W - 1)) && (shifted == SYNC_PAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-framed serial receiver: sync, MSB-first payload, optional parity, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to compile in the even-parity bit and its check.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = cnt_w(DATA_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              par_err;
  logic              sync_hit;
  logic              hunt_sample;
  logic              sync_clear;

  assign hunt_sample = bit_en && (state_q == ST_HUNT);
  // Leaving STOP is the only way back into HUNT, so the window restarts empty there.
  assign sync_clear  = bit_en && (state_q == ST_STOP);

  sync_detect #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (sync_clear),
    .sample_i (hunt_sample),
    .din_i    (din),
    .match_o  (sync_hit)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (bit_en) begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          payload_d = {payload_q[DATA_W-2:0], din};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ST_PARITY: begin
          par_err_d = (^payload_q) ^ din;
          state_d   = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (din && !par_err) begin
            data_d  = payload_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      cnt_q     <= '0;
      payload_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != ST_HUNT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - table-driven frame vectors with a pulse scoreboard for serial_frame_rx.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] pre;
    int         pre_len;
    logic [7:0] payload;
    logic       stop;
    logic       par_flip;
    logic       gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every pulse must match the oldest outstanding frame expectation.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      check("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        check("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic step(input logic b, input logic en);
    @(negedge clk);
    din    = b;
    bit_en = en;
  endtask

  task automatic put(input logic b, input logic gap);
    if (gap) step(1'($urandom), 1'b0);
    step(b, 1'b1);
  endtask

  task automatic add(input logic [7:0] pre, input int pre_len, input logic [7:0] payload,
                     input logic stop, input logic par_flip, input logic gap,
                     input logic exp_err, input logic [7:0] exp_data);
    vec_t v;
    v.pre = pre; v.pre_len = pre_len; v.payload = payload; v.stop = stop;
    v.par_flip = par_flip; v.gap = gap; v.exp_err = exp_err; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.is_err = v.exp_err;
    e.data   = v.exp_data;
    sb.push_back(e);
    for (int i = v.pre_len - 1; i >= 0; i--) put(v.pre[i], v.gap);
    for (int i = 7; i >= 0; i--) begin
      put(v.payload[i], v.gap);
      if (i == 7) check("busy_after_sync", 32'(busy), 32'd1);
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    put((^v.payload) ^ v.par_flip, v.gap);
`endif
    put(v.stop, v.gap);
    step(1'($urandom), 1'b0);
    check("pulse_latency", 32'(data_valid | frame_err), 32'd1);
    step(1'($urandom), 1'b0);
    check("pulse_width", 32'(data_valid | frame_err), 32'd0);
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    add(8'b1101,    4, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    add(8'b1101,    4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    add(8'b1101,    4, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    add(8'b1101,    4, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
    add(8'b11101,   5, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    add(8'b0001101, 7, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 8'h81);
    add(8'b1101,    4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    add(8'b1101,    4, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
    add(8'b1101,    4, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
`endif

    // Reset held with bit_en high and din toggling: reset must win.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'(i), 1'b1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    foreach (vecs[k]) send_frame(vecs[k]);

    // Reset after four payload bits: no pulse, idle, data_out back to reset value.
    for (int i = 3; i >= 0; i--) put(1'(4'b1101 >> i), 1'b0);
    for (int i = 0; i < 4; i++) put(1'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; din = 1'b1;
    @(negedge clk);
    rst = 1'b0; bit_en = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    step(1'b0, 1'b0);
    check("midrst_no_pulse", 32'(data_valid | frame_err), 32'd0);
    begin
      vec_t v;
      v.pre = 8'b1101; v.pre_len = 4; v.payload = 8'h3C; v.stop = 1'b1;
      v.par_flip = 1'b0; v.gap = 1'b0; v.exp_err = 1'b0; v.exp_data = 8'h3C;
      send_frame(v);
    end

    repeat (4) step(1'b0, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8: number of payload bits per frame.
REQ-002 Parameter SYNC_W, default 4: sync pattern width in bits.
REQ-003 Parameter SYNC_PAT, default 4'b1101: sync pattern, first-received bit in the MSB.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 din  input  1  serial bit stream from the upstream shift-register stage.
REQ-007 bit_en  input  1  sample qualifier; din is consumed only on edges where bit_en=1.
REQ-008 data_out  output  DATA_W  last correctly received payload.
REQ-009 data_valid  output  1  one-cycle pulse: data_out updated.
REQ-010 frame_err  output  1  one-cycle pulse: frame rejected.
REQ-011 busy  output  1  high while a frame is being received after sync.

Function
REQ-012 Frame format, in order: SYNC_W sync bits, DATA_W payload bits (MSB first), optional parity bit, one stop bit (1).
REQ-013 States: HUNT, DATA, PARITY (only if compiled in), STOP; with bit_en=0 the state and all registers hold.
REQ-014 HUNT shall use a SYNC_W-bit sliding history and a fill count, so that overlapping patterns are detected.
REQ-015 HUNT shall go to DATA on the sample that completes a history equal to SYNC_PAT, and only after at least SYNC_W samples since HUNT was entered.
REQ-016 DATA shall shift din into a payload register, LSB-side insert, and count samples modulo DATA_W.
REQ-017 After the DATA_W-th sample, DATA shall go to PARITY when enabled, otherwise to STOP.
REQ-018 PARITY shall sample one bit; the frame is bad if the XOR of the payload and the parity bit is not 0 (even parity).
REQ-019 STOP, stop bit 1 and no parity error: data_out shall load the payload, and data_valid shall be high for exactly the one cycle after the stop-sampling edge.
REQ-020 STOP, stop bit 0 or parity error: frame_err shall pulse for one cycle with the same timing, and data_out shall hold its previous value.
REQ-021 After STOP, HUNT shall restart with the history and fill count cleared; frame bits are never reused for sync.
REQ-022 busy shall be 1 in DATA, PARITY and STOP, and 0 in HUNT.
REQ-023 data_valid and frame_err shall never be asserted in the same cycle, and each shall stay high for only one cycle, even if bit_en=0 in the following cycle.

Reset
REQ-024 rst shall have priority over bit_en and take effect mid-frame without producing any pulse.
REQ-025 Reset values: state HUNT, history 0, fill count 0, bit count 0, data_out 0, data_valid 0, frame_err 0, busy 0.

Configuration
REQ-026 With macro SERIAL_FRAME_RX_PARITY_EN defined, the PARITY state and the even-parity check shall be present.
REQ-027 Without SERIAL_FRAME_RX_PARITY_EN, DATA shall go directly to STOP, and no parity bit is expected in the stream.

Structure
REQ-028 Shared package serial_pkg shall hold the state enum typedef and the default DATA_W, SYNC_W and SYNC_PAT constants.
REQ-029 Sync search (history register, fill count and match compare) shall be a sub-module named sync_detect, with a clear input driven from HUNT entry.

Verification
REQ-030 Case 1, parity off: rst; then 1101, 10100101, stop 1 -> data_valid one cycle after the stop sample, data_out=8'hA5, frame_err=0.
REQ-031 Case 2: repeat case 1 with stop bit 0 -> frame_err pulse, no data_valid, data_out stays 8'hA5.
REQ-032 Case 3, parity on: 1101, 00000001, parity 0, stop 1 -> frame_err pulse; the same frame with parity 1 -> data_valid, data_out=8'h01.
REQ-033 Case 4: case 1 stimulus with bit_en low on alternate cycles -> identical result; latency counted in enabled samples only.
REQ-034 Case 5: rst after 4 payload bits -> busy=0 the next cycle and no pulses; then a full frame with payload 8'h3C -> data_out=8'h3C.
REQ-035 Case 6: stream 11101 followed by payload 8'hFF and stop 1 -> sync accepted on the fifth bit, data_out=8'hFF.
